// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 serial transmitter.
// Bytes enter a small FIFO over a valid/ready handshake and are sent
// LSB-first. Start, data and stop bits each last DIV system clocks.
module uart_tx #(
  parameter int CLKRATE  = 3_579_545,
  parameter int BAUDRATE = 9600,
  parameter int DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int DIV = (CLKRATE + BAUDRATE / 2) / BAUDRATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW  = AW + 1;

  localparam logic [CW-1:0] BAUD_LAST  = CW'(DIV - 1);
  localparam logic [NW-1:0] FULL_COUNT = NW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;
  logic          r_in_ready;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [NW-1:0] r_count;
  logic [7:0]    r_mem [DEPTH];

  logic          w_push;
  logic          w_pop;
  logic          w_baud_end;
  logic [1:0]    w_state_nxt;
  logic [NW-1:0] w_count_nxt;

  // in_ready is the registered !full, so a push can never hit a full FIFO.
  assign w_push     = in_valid && r_in_ready;
  assign w_baud_end = (r_baud_cnt == BAUD_LAST);

  assign in_ready = r_in_ready;
  assign tx       = r_tx;
  assign busy     = r_busy;

  // Next-state and pop decision; a pop happens only when leaving IDLE or STOP.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_baud_end && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
      end
      default: begin
        if (w_baud_end) begin
          if (r_count != '0) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
    endcase
  end

  // FIFO occupancy after this edge; simultaneous push and pop cancel out.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + NW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - NW'(1);
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset; only pointers and count define validity.
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  // FIFO pointers, count and registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != FULL_COUNT);
    end
  end

  // Frame sequencer: state, baud counter, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_shift    <= r_mem[r_rd_ptr];
        r_bit_idx  <= '0;
        r_baud_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_baud_cnt <= w_baud_end ? '0 : r_baud_cnt + CW'(1);
        if ((r_state == S_DATA) && w_baud_end) begin
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 3'd1;
        end
      end
    end
  end

  // Registered line driver and busy flag; tx lags the state by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      case (r_state)
        S_START: r_tx <= 1'b0;
        S_DATA:  r_tx <= r_shift[0];
        default: r_tx <= 1'b1;
      endcase
      r_busy <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx with DIV = 16 (CLKRATE=16, BAUDRATE=1).
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;

  uart_tx #(.CLKRATE(16), .BAUDRATE(1), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Cycle number = count of rising edges so far; read it on falling edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rx_q[$];
  int         fall_q[$];
  bit         ok_q[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit i = line level in bit slot i (slot 0 = start)
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one byte for one clock; k is the edge that samples it.
  task automatic drive(input logic v, input logic [7:0] d, output bit acc, output int k);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    acc      = v && in_ready;
    k        = cyc + 1;
    @(posedge clk);
  endtask

  task automatic release_valid();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t = 0;
    while (busy !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    fall_q.delete();
    ok_q.delete();
  endtask

  // Line decoder: samples every clock of a frame, requires each bit to be
  // stable for all 16 clocks and the stop bit to be high. Reset aborts it.
  logic [9:0] dec_v;
  bit         dec_ok;
  bit         dec_abort;
  int         dec_start;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        dec_start = cyc;
        dec_ok    = 1'b1;
        dec_abort = 1'b0;
        dec_v     = '0;
        for (int i = 0; i < 160; i++) begin
          if (i != 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            dec_abort = 1'b1;
            break;
          end
          if (i % 16 == 0) dec_v[i/16] = tx;
          else if (tx !== dec_v[i/16]) dec_ok = 1'b0;
        end
        if (!dec_abort) begin
          if (dec_v[9] !== 1'b1) dec_ok = 1'b0;
          rx_q.push_back(dec_v[8:1]);
          fall_q.push_back(dec_start);
          ok_q.push_back(dec_ok);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit         acc;
    int         k;
    int         k0;
    int         bad;
    logic [9:0] got;
    logic [5:0] mask;
    logic [7:0] acc_q[$];
    logic [7:0] d;
    int         guard;

    // Hand-computed frames, slot order start, b0..b7, stop.
    vecs[0] = '{data: 8'hA5, frame: 10'b1101001010};
    vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
    vecs[3] = '{data: 8'h3C, frame: 10'b1001111000};
    vecs[4] = '{data: 8'h01, frame: 10'b1000000010};
    vecs[5] = '{data: 8'h80, frame: 10'b1100000000};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // 1. Idle after reset.
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("t1_idle_bad_cycles", bad, 0);
    check("t1_no_frames", rx_q.size(), 0);

    // 2. Single frames from the vector table, slot by slot.
    foreach (vecs[v]) begin
      clear_rx();
      drive(1'b1, vecs[v].data, acc, k);
      release_valid();
      check("t2_accept", acc, 1'b1);
      check("t2_busy_rise", busy, 1'b1);
      got = '0;
      for (int i = 0; i < 10; i++) begin
        wait_until(k + 2 + 16 * i + 8);
        got[i] = tx;
      end
      check($sformatf("t2_frame_%02h", vecs[v].data), got, vecs[v].frame);
      wait_until(k + 1);
      wait_until(k + 160);
      check("t2_busy_late", busy, 1'b1);
      wait_until(k + 162);
      check("t2_busy_fall", busy, 1'b0);
      check("t2_tx_idle", tx, 1'b1);
      check("t2_nframes", rx_q.size(), 1);
      if (rx_q.size() == 1) begin
        check("t2_byte", rx_q[0], vecs[v].data);
        check("t2_fall_latency", fall_q[0] - k, 2);
        check("t2_bit_widths", ok_q[0], 1'b1);
      end
    end

    // 3. Three back-to-back frames with no idle gap.
    clear_rx();
    drive(1'b1, 8'h00, acc, k0);
    drive(1'b1, 8'hFF, acc, k);
    drive(1'b1, 8'h3C, acc, k);
    release_valid();
    wait_frames(3, 700);
    check("t3_nframes", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check("t3_byte0", rx_q[0], 8'h00);
      check("t3_byte1", rx_q[1], 8'hFF);
      check("t3_byte2", rx_q[2], 8'h3C);
      check("t3_first_fall", fall_q[0] - k0, 2);
      check("t3_gap01", fall_q[1] - fall_q[0], 160);
      check("t3_gap12", fall_q[2] - fall_q[1], 160);
      check("t3_widths", {ok_q[0], ok_q[1], ok_q[2]}, 3'b111);
    end
    wait_idle("t3_idle", 300);

    // 4. Six pushes into a DEPTH=4 FIFO: one in flight, four queued, one dropped.
    clear_rx();
    mask = '0;
    for (int i = 0; i < 6; i++) begin
      d = 8'(17 * (i + 1));
      drive(1'b1, d, acc, k);
      mask[i] = acc;
    end
    release_valid();
    check("t4_accept_mask", mask, 6'b011111);
    check("t4_in_ready_full", in_ready, 1'b0);
    wait_frames(5, 1000);
    wait_idle("t4_idle", 400);
    repeat (200) @(negedge clk);
    check("t4_nframes", rx_q.size(), 5);
    check("t4_in_ready_after", in_ready, 1'b1);
    if (rx_q.size() == 5) begin
      for (int i = 0; i < 5; i++) check($sformatf("t4_byte%0d", i), rx_q[i], 8'(17 * (i + 1)));
    end

    // 5. Reset in the middle of a data bit with two bytes queued.
    clear_rx();
    drive(1'b1, 8'h55, acc, k);
    drive(1'b1, 8'hAA, acc, k0);
    drive(1'b1, 8'hCC, acc, k0);
    release_valid();
    wait_until(k + 2 + 40);
    check("t5_pre_tx", tx, 1'b0);
    check("t5_pre_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_tx", tx, 1'b1);
    check("t5_async_busy", busy, 1'b0);
    check("t5_async_ready", in_ready, 1'b1);
    repeat (3) @(negedge clk);
    clear_rx();
    rst_n = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("t5_post_bad_cycles", bad, 0);
    check("t5_no_frames", rx_q.size(), 0);

    // 6. Random pushes with backpressure; decoded stream must equal accepted stream.
    clear_rx();
    guard = 0;
    while (acc_q.size() < 300 && guard < 60000) begin
      drive(($urandom_range(0, 2) != 0), 8'($urandom), acc, k);
      if (acc) acc_q.push_back(in_data);
      guard++;
    end
    release_valid();
    check("t6_accepted", acc_q.size(), 300);
    wait_frames(acc_q.size(), 6 * 160 + 200);
    wait_idle("t6_idle", 400);
    check("t6_nframes", rx_q.size(), acc_q.size());
    bad = 0;
    for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++) begin
      if (rx_q[i] !== acc_q[i]) bad++;
    end
    check("t6_byte_errors", bad, 0);
    bad = 0;
    for (int i = 0; i < ok_q.size(); i++) begin
      if (!ok_q[i]) bad++;
      if (i > 0 && fall_q[i] - fall_q[i-1] < 160) bad++;
    end
    check("t6_width_errors", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
